uart_rx: RTL

- UART receive side of the serial link: recovers 8N1 frames (start 0, LSB-first data, stop 1) from the asynchronous rx line.
- Uses a shared oversampling tick from the baud generator and delivers each received byte with a single-cycle valid strobe.
- Sits beside the transmitter and shares its baud generator, one instance per UART port.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (used by receiver and
// transmitter), default frame/oversampling constants, line idle level and
// a parity helper.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // True when the data XOR plus received parity bit disagrees with the
  // selected parity sense (odd=1 expects an odd count of ones overall).
  function automatic logic parity_bad(input logic data_xor,
                                      input logic par_bit,
                                      input logic odd);
    return ((data_xor ^ par_bit) != odd);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. RST_VAL sets
// the value both stages take during reset so the output does not show a
// false transition when reset is released.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1-style frames (start 0, LSB-first data, stop 1)
// using a shared OVERSAMPLE x baud tick. Emits one-cycle rx_valid or
// frame_err strobes at the stop-bit midpoint.
// Optional macro UART_RX_PARITY_EN adds a parity bit between data and stop,
// a parity_odd select input and a parity_err strobe output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Start bit is checked half a bit in; data/parity/stop one full bit apart.
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;
  logic start_edge_s;

  uart_state_e            state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  uart_sync2 #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Falling edge of the synchronized line; a line held low never re-triggers.
  assign start_edge_s = rx_prev_q & ~rx_s;

  // Next-state, counter and strobe logic for the receive FSM.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_edge_s) begin
          state_d    = START;
          tick_cnt_d = '0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_cnt_q == HALF_M1) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_cnt_q == FULL_M1) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              state_d = DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_tick) begin
          if (tick_cnt_q == FULL_M1) begin
            par_bit_d  = rx_s;
            tick_cnt_d = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`endif
      STOP: begin
        if (os_tick) begin
          if (tick_cnt_q == FULL_M1) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            tick_cnt_d = '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (parity_bad(^shift_q, par_bit_q, parity_odd)) begin
                parity_err_d = 1'b1;
              end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end
`else
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, data path and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q   <= UART_IDLE_LEVEL;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
